// File: rtl/conv_window_sequencer_if.sv
// rtl/conv_window_sequencer_if.sv - control, stream and ALU bundle of the convolution window sequencer
//
// Purpose: groups every non-clock signal of conv_window_sequencer.
//   master : environment side (drives start/abort/streams/ALU result, takes out stream)
//   slave  : sequencer side
// Signals:
//   start, abort, num_windows          job control
//   cfg_valid/cfg_ready/cfg_data       kernel byte stream
//   in_valid/in_ready/in_data          image-window byte stream
//   A_flat, B_flat                     kernel / window registers to the ALU
//   alu_result, alu_ovf                ALU outputs
//   out_valid/out_ready/out_data/out_ovf  result stream
//   busy, done, win_count, ovf_count   status
interface conv_window_sequencer_if #(
  parameter int CNT_W = 16
);
  logic              start;
  logic              abort;
  logic [CNT_W-1:0]  num_windows;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [7:0]        cfg_data;
  logic              in_valid;
  logic              in_ready;
  logic [7:0]        in_data;
  logic [199:0]      A_flat;
  logic [199:0]      B_flat;
  logic signed [7:0] alu_result;
  logic              alu_ovf;
  logic              out_valid;
  logic              out_ready;
  logic [7:0]        out_data;
  logic              out_ovf;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  win_count;
  logic [CNT_W-1:0]  ovf_count;

  modport master (
    output start, abort, num_windows, cfg_valid, cfg_data, in_valid, in_data,
           alu_result, alu_ovf, out_ready,
    input  cfg_ready, in_ready, A_flat, B_flat, out_valid, out_data, out_ovf,
           busy, done, win_count, ovf_count
  );

  modport slave (
    input  start, abort, num_windows, cfg_valid, cfg_data, in_valid, in_data,
           alu_result, alu_ovf, out_ready,
    output cfg_ready, in_ready, A_flat, B_flat, out_valid, out_data, out_ovf,
           busy, done, win_count, ovf_count
  );
endinterface

// File: rtl/conv_window_sequencer.sv
// rtl/conv_window_sequencer.sv - loads a 5x5 kernel once, then streams windows through the conv ALU
//
// Purpose: per job, load 25 kernel bytes into A_flat, then for each of num_windows windows
//   load 25 bytes into B_flat, capture the ALU result for one cycle and present it on the
//   out stream until accepted. done pulses once after the last window is accepted.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : conv_window_sequencer_if.slave (job control, streams, ALU, status)
module conv_window_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  conv_window_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_K,
    S_LOAD_W,
    S_CALC,
    S_OUT
  } state_t;

  state_t           r_state;
  logic [4:0]       r_k_idx;
  logic [4:0]       r_w_idx;
  logic [199:0]     r_a_flat;
  logic [199:0]     r_b_flat;
  logic [CNT_W-1:0] r_num_windows;
  logic [CNT_W-1:0] r_win_count;
  logic [CNT_W-1:0] r_ovf_count;
  logic [7:0]       r_out_data;
  logic             r_out_ovf;
  logic             r_out_valid;
  logic             r_cfg_ready;
  logic             r_in_ready;
  logic             r_busy;
  logic             r_done;

  logic [CNT_W-1:0] w_win_next;

  assign w_win_next = r_win_count + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_k_idx       <= '0;
      r_w_idx       <= '0;
      r_a_flat      <= '0;
      r_b_flat      <= '0;
      r_num_windows <= '0;
      r_win_count   <= '0;
      r_ovf_count   <= '0;
      r_out_data    <= '0;
      r_out_ovf     <= 1'b0;
      r_out_valid   <= 1'b0;
      r_cfg_ready   <= 1'b0;
      r_in_ready    <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_done <= 1'b0;
      // Abort wins over any handshake in the same cycle; data registers and counters are kept.
      if (r_state != S_IDLE && bus.abort) begin
        r_state     <= S_IDLE;
        r_busy      <= 1'b0;
        r_cfg_ready <= 1'b0;
        r_in_ready  <= 1'b0;
        r_out_valid <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (bus.start && bus.num_windows != '0) begin
              r_num_windows <= bus.num_windows;
              r_win_count   <= '0;
              r_ovf_count   <= '0;
              r_k_idx       <= '0;
              r_w_idx       <= '0;
              r_busy        <= 1'b1;
              r_cfg_ready   <= 1'b1;
              r_state       <= S_LOAD_K;
            end
          end
          // Ready flags are registered alongside the state, so valid alone marks a handshake here.
          S_LOAD_K: begin
            if (bus.cfg_valid) begin
              r_a_flat[{r_k_idx, 3'b000} +: 8] <= bus.cfg_data;
              if (r_k_idx == 5'd24) begin
                r_k_idx     <= '0;
                r_cfg_ready <= 1'b0;
                r_in_ready  <= 1'b1;
                r_state     <= S_LOAD_W;
              end else begin
                r_k_idx <= r_k_idx + 5'd1;
              end
            end
          end
          S_LOAD_W: begin
            if (bus.in_valid) begin
              r_b_flat[{r_w_idx, 3'b000} +: 8] <= bus.in_data;
              if (r_w_idx == 5'd24) begin
                r_w_idx    <= '0;
                r_in_ready <= 1'b0;
                r_state    <= S_CALC;
              end else begin
                r_w_idx <= r_w_idx + 5'd1;
              end
            end
          end
          // One cycle for the ALU to settle on the freshly loaded window.
          S_CALC: begin
            r_out_data  <= bus.alu_result;
            r_out_ovf   <= bus.alu_ovf;
            if (bus.alu_ovf && r_ovf_count != '1) begin
              r_ovf_count <= r_ovf_count + CNT_W'(1);
            end
            r_out_valid <= 1'b1;
            r_state     <= S_OUT;
          end
          S_OUT: begin
            if (bus.out_ready) begin
              r_out_valid <= 1'b0;
              r_win_count <= w_win_next;
              if (w_win_next == r_num_windows) begin
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_state <= S_IDLE;
              end else begin
                r_in_ready <= 1'b1;
                r_state    <= S_LOAD_W;
              end
            end
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.cfg_ready = r_cfg_ready;
  assign bus.in_ready  = r_in_ready;
  assign bus.A_flat    = r_a_flat;
  assign bus.B_flat    = r_b_flat;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_ovf   = r_out_ovf;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.win_count = r_win_count;
  assign bus.ovf_count = r_ovf_count;

endmodule

// File: doc/conv_window_sequencer.md
CONV_WINDOW_SEQUENCER -- requirements
Module: conv_window_sequencer

Interface
REQ-001 SHALL have parameter CNT_W, default 16, giving the window-counter width.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1, begins a job when sampled high in IDLE.
REQ-005 SHALL have port abort, input, 1, synchronous job cancel.
REQ-006 SHALL have port num_windows, input, CNT_W, number of windows in the job; latched at start.
REQ-007 SHALL have ports cfg_valid (input, 1), cfg_ready (output, 1) and cfg_data (input, 8), the kernel byte stream.
REQ-008 SHALL have ports in_valid (input, 1), in_ready (output, 1) and in_data (input, 8), the image-window byte stream.
REQ-009 SHALL have ports A_flat and B_flat, output, 200 each, the kernel and window registers driven to the convolution ALU.
REQ-010 SHALL have ports alu_result (input, 8, signed) and alu_ovf (input, 1), the convolution ALU outputs.
REQ-011 SHALL have ports out_valid (output, 1), out_ready (input, 1), out_data (output, 8) and out_ovf (output, 1), the result stream.
REQ-012 SHALL have outputs busy (1), done (1), win_count (CNT_W) and ovf_count (CNT_W).

Function
REQ-013 SHALL implement states IDLE, LOAD_K, LOAD_W, CALC and OUT.
REQ-014 IDLE: busy=0; start=1 with num_windows!=0 SHALL latch num_windows, clear win_count and ovf_count, and go to LOAD_K.
REQ-015 start with num_windows==0 SHALL be ignored; start outside IDLE SHALL be ignored.
REQ-016 LOAD_K: cfg_ready=1; the k-th accepted byte (k=0..24) SHALL be written to A_flat[k*8 +: 8]; after byte 24 go to LOAD_W.
REQ-017 LOAD_W: in_ready=1; the j-th accepted byte SHALL be written to B_flat[j*8 +: 8]; after byte 24 go to CALC.
REQ-018 A byte SHALL be accepted only on a cycle where valid and ready are both high; byte indices SHALL hold while valid is low.
REQ-019 cfg_ready SHALL be 0 outside LOAD_K; in_ready SHALL be 0 outside LOAD_W.
REQ-020 CALC SHALL last 1 cycle, register alu_result into out_data and alu_ovf into out_ovf, increment ovf_count if alu_ovf=1 (saturating at all-ones), and go to OUT.
REQ-021 Latency: if the 25th window byte is accepted at edge N, out_valid SHALL be 1 from the cycle after edge N+1.
REQ-022 OUT: out_valid=1; out_data and out_ovf SHALL be stable until out_valid && out_ready.
REQ-023 On the OUT handshake, win_count SHALL increment; if the new value equals the latched num_windows, go to IDLE and pulse done for exactly 1 cycle; otherwise go to LOAD_W.
REQ-024 The kernel SHALL NOT be reloaded between windows of a job; A_flat SHALL hold its value until the next job's LOAD_K.
REQ-025 busy SHALL be 1 in every state except IDLE.
REQ-026 abort=1 in any non-IDLE state SHALL force IDLE on the next edge, with done=0, out_valid=0, and win_count/ovf_count holding their values.
REQ-027 abort SHALL take priority over any simultaneous handshake in the same cycle.
REQ-028 A_flat and B_flat SHALL NOT be cleared by abort.

Reset
REQ-029 rst_n=0 SHALL immediately force IDLE, including mid-job.
REQ-030 rst_n=0 SHALL drive busy, done, cfg_ready, in_ready, out_valid, out_ovf=0; out_data=0; win_count=0; ovf_count=0; A_flat=0; B_flat=0; all byte indices=0.
REQ-031 After rst_n deasserts, the block SHALL wait for start.

Verification
REQ-032 Single window: num_windows=1, kernel all 8'd1, window all 8'd2, ALU model gives 50 -> out_data=50, out_ovf=0, done pulses 1 cycle after the handshake, win_count=1.
REQ-033 Backpressure: hold out_ready=0 for 10 cycles in OUT -> out_valid remains 1, out_data unchanged, in_ready=0 throughout.
REQ-034 Multi-window: num_windows=3, kernel loaded once, second window forces ALU overflow (sum 200 -> result 127) -> three outputs, ovf_count=1, exactly 25 cfg bytes accepted.
REQ-035 Gapped input: in_valid toggles every other cycle -> bytes land at correct B_flat indices; out_valid only after the 25th byte.
REQ-036 Abort after 10 window bytes -> IDLE next cycle, done=0; a new start reloads the kernel from cfg byte 0.
REQ-037 rst_n pulsed low during OUT -> all outputs zero asynchronously; start with num_windows=0 afterward -> busy stays 0.
